dense_mac_sequencer: RTL and testbench
======================================

Name: dense_mac_sequencer

Overview:
- Sequences a single shared multiply-accumulate unit through a fully connected layer: `out[j] = round(sum_i(W[i][j]*x[i]) / SCALE) + b[j]`.
- Drives read addresses into external input, kernel and bias memories. Writes each finished output to an external output memory.
- Sits between the layer-level start/done chain and the layer memories. It replaces the all-at-once dense datapath with a time-multiplexed one: one product per cycle.

Parameters:
- `IN_FEATURES`, 56, input vector length (>=1)
- `OUT_FEATURES`, 10, output vector length (>=1)
- `SCALE`, 128, fixed-point rescale divisor (>=2, even)
- `AW`, 16, address width for all memory ports; must hold `IN_FEATURES*OUT_FEATURES-1`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  run request; sampled only in IDLE
- `busy`  out  1  high from the cycle after start is accepted until done
- `done`  out  1  one-cycle pulse at end of run
- `in_addr`  out  AW  input-vector read address (i)
- `in_data`  in  32  signed, valid 1 cycle after `in_addr`
- `w_addr`  out  AW  kernel read address = `i*OUT_FEATURES + j`
- `w_data`  in  32  signed, valid 1 cycle after `w_addr`
- `b_addr`  out  AW  bias read address (j)
- `b_data`  in  32  signed, valid 1 cycle after `b_addr`
- `out_we`  out  1  output write strobe
- `out_addr`  out  AW  output write address (j)
- `out_data`  out  32  signed output value

Behaviour:
- Reset (async, active-low): state IDLE, i=j=0, accumulator=0.
  - All outputs 0: `busy`, `done`, `out_we`, every address, `out_data`.
  - Reset mid-run aborts immediately. No further writes occur. Partial output memory contents are left as-is.
- All memories are synchronous read with 1-cycle latency. The sequencer never stalls.
- States: IDLE, MAC, DRAIN, WRITE, FIN.
- IDLE:
  - `start=1` -> MAC, with i=0, j=0, acc=0, `busy`<=1.
  - `start=0` -> stay in IDLE.
- MAC:
  - Each cycle drives `in_addr=i`, `w_addr=i*OUT_FEATURES+j`, `b_addr=j`.
  - A 1-cycle valid flag tracks the returned data. When it is set, acc += `w_data*in_data`.
  - i increments each cycle. After issuing i=IN_FEATURES-1 -> DRAIN.
- DRAIN: accumulate the final product. `b_data` is stable because `b_addr` has held j. -> WRITE.
- WRITE:
  - Drives `out_we=1`, `out_addr=j`, `out_data=result`. acc is cleared.
  - If j==OUT_FEATURES-1 -> FIN. Otherwise j++, i=0 -> MAC.
- FIN: `done=1` for exactly one cycle, `busy`<=0 -> IDLE. A new start can be accepted on the cycle after FIN.
- `start` while not IDLE is ignored. No queueing.
- Timing:
  - Each output takes IN_FEATURES+2 cycles.
  - Cycle 0 is the edge sampling `start`. `done` is high in cycle `OUT_FEATURES*(IN_FEATURES+2)+1`.
- Arithmetic:
  - Operands are sign-extended to 64 bits. The product is 64-bit signed. acc is 64-bit signed and wraps on overflow.
  - `result = trunc32( (acc + SCALE/2) / SCALE ) + b_data`.
  - The division is signed and truncates toward zero. The final add is 32-bit and wraps.
- `out_we` is high only in WRITE. `out_addr` and `out_data` hold their last value otherwise.

Optional Feature:
- Macro `DENSE_SEQ_RELU_EN`.
  - Defined: `out_data` is clamped to 0 when the 32-bit result is negative. This is applied after the bias add.
  - Undefined: `out_data` is the raw wrapped 32-bit result.
- Timing is identical in both builds.

Test Plan:
All scenarios use IN_FEATURES=3, OUT_FEATURES=2, SCALE=128.
1. Basic run.
   - Stimulus: x=[128,256,-128]; all W=128; b=[5,-10]; one-cycle `start`.
   - Required: writes out[0]=261, out[1]=246 (sum 32768 -> 256). `done` high exactly at cycle 11. `busy` high cycles 1-11.
2. Rounding.
   - Stimulus: x=[1,0,0]; W[0][0]=-65, W[0][1]=-192; b=0.
   - Required: out[0]=0 (-1/128 truncates toward zero), out[1]=-1 (-128/128).
3. Start handling.
   - Stimulus: hold `start`=1 continuously.
   - Required: the second run begins only the cycle after `done`, with no start accepted mid-run. Exactly 2 writes per run; the address sequence w_addr = 0,2,4 then 1,3,5 repeats.
4. Reset mid-run.
   - Stimulus: assert `rst_n`=0 during MAC of j=1.
   - Required: all outputs 0 immediately and no further `out_we`. After release plus `start`, the full results of test 1 are reproduced.
5. ReLU build.
   - Stimulus: configuration of test 2 with b=[0,-3].
   - Required: undefined macro gives out[1]=-4; with `DENSE_SEQ_RELU_EN` defined, out[1]=0 and out[0]=0.
6. Wrap.
   - Stimulus: x=[0x7FFFFFFF, 0x7FFFFFFF, 0]; W=0x7FFFFFFF; b=0.
   - Required: out equals `trunc32((2*(2^31-1)^2 + 64)/128)`, matching the 64-bit reference model bit-exactly.

Source files
------------

// File: rtl/dense_mac_sequencer.sv
// Time-multiplexed fully connected layer: one shared MAC, one product per cycle, IN_FEATURES+2 cycles per output.
// Build option DENSE_SEQ_RELU_EN clamps negative outputs to zero; timing is identical either way.
module dense_mac_sequencer #(
  parameter int IN_FEATURES  = 56,
  parameter int OUT_FEATURES = 10,
  parameter int SCALE        = 128,
  parameter int AW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] in_addr,
  input  logic [31:0]   in_data,
  output logic [AW-1:0] w_addr,
  input  logic [31:0]   w_data,
  output logic [AW-1:0] b_addr,
  input  logic [31:0]   b_data,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [31:0]   out_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [AW-1:0] I_LAST = AW'(IN_FEATURES - 1);
  localparam logic [AW-1:0] J_LAST = AW'(OUT_FEATURES - 1);
  localparam logic [AW-1:0] W_STEP = AW'(OUT_FEATURES);
  localparam logic [AW-1:0] ONE    = AW'(1);

  localparam logic signed [63:0] SCALE_S = 64'(SCALE);
  localparam logic signed [63:0] HALF_S  = 64'(SCALE / 2);

  logic [2:0]         state;
  logic [AW-1:0]      i_cnt;
  logic [AW-1:0]      j_cnt;
  logic [AW-1:0]      w_idx;
  logic               prod_vld;
  logic signed [63:0] acc;
  logic signed [63:0] in_ext;
  logic signed [63:0] w_ext;
  logic signed [63:0] prod;
  logic signed [63:0] acc_sum;
  logic signed [63:0] rnd_sum;
  logic [31:0]        quot_lo;
  logic [31:0]        result;
  logic [31:0]        out_val;

  // Addresses come straight from the counters; w_idx tracks i*OUT_FEATURES+j without a multiplier.
  assign in_addr = i_cnt;
  assign w_addr  = w_idx;
  assign b_addr  = j_cnt;

  assign in_ext  = {{32{in_data[31]}}, in_data};
  assign w_ext   = {{32{w_data[31]}}, w_data};
  assign prod    = in_ext * w_ext;
  assign acc_sum = prod_vld ? acc + prod : acc;
  assign rnd_sum = acc_sum + HALF_S;
  assign quot_lo = 32'(rnd_sum / SCALE_S);
  assign result  = quot_lo + b_data;

`ifdef DENSE_SEQ_RELU_EN
  assign out_val = result[31] ? 32'd0 : result;
`else
  assign out_val = result;
`endif

  // Memory data lags the address by one cycle, so the product is valid the cycle after each MAC issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= (state == S_MAC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i_cnt <= '0;
      j_cnt <= '0;
      w_idx <= '0;
      acc   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_MAC;
            i_cnt <= '0;
            j_cnt <= '0;
            w_idx <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (i_cnt == I_LAST) begin
            state <= S_DRAIN;
          end else begin
            i_cnt <= i_cnt + ONE;
            w_idx <= w_idx + W_STEP;
          end
        end
        S_DRAIN: begin
          acc   <= acc_sum;
          state <= S_WRITE;
        end
        S_WRITE: begin
          acc <= '0;
          if (j_cnt == J_LAST) begin
            state <= S_FIN;
          end else begin
            j_cnt <= j_cnt + ONE;
            i_cnt <= '0;
            w_idx <= j_cnt + ONE;
            state <= S_MAC;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The result is registered at the DRAIN edge (b_data is valid there) so it is presented throughout WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      done     <= 1'b0;
    end else begin
      out_we <= 1'b0;
      done   <= 1'b0;
      if (state == S_DRAIN) begin
        out_we   <= 1'b1;
        out_addr <= j_cnt;
        out_data <= out_val;
      end
      if (state == S_WRITE && j_cnt == J_LAST) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// Bench for dense_mac_sequencer: memory models, a per-run capture, and a plain-arithmetic reference model.
module tb_dense_mac_sequencer;
  localparam int NI  = 3;
  localparam int NO  = 2;
  localparam int SC  = 128;
  localparam int AW  = 16;
  localparam int PER = NI + 2;
  localparam int RUN = NO * PER + 1;
  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, out_we;
  logic [AW-1:0] in_addr, w_addr, b_addr, out_addr;
  logic [31:0] in_data, w_data, b_data, out_data;

  logic signed [31:0] x_mem [NI];
  logic signed [31:0] w_mem [NI*NO];
  logic signed [31:0] b_mem [NO];

  logic          c_busy [1:MAXC];
  logic          c_done [1:MAXC];
  logic          c_we   [1:MAXC];
  logic [AW-1:0] c_ia   [1:MAXC];
  logic [AW-1:0] c_wa   [1:MAXC];
  logic [AW-1:0] c_ba   [1:MAXC];
  logic [AW-1:0] c_oa   [1:MAXC];
  logic [31:0]   c_od   [1:MAXC];

  int total = 0;
  int bad = 0;

  dense_mac_sequencer #(.IN_FEATURES(NI), .OUT_FEATURES(NO), .SCALE(SC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data <= (int'(in_addr) < NI) ? x_mem[int'(in_addr)] : 32'd0;
    w_data  <= (int'(w_addr) < NI*NO) ? w_mem[int'(w_addr)] : 32'd0;
    b_data  <= (int'(b_addr) < NO) ? b_mem[int'(b_addr)] : 32'd0;
  end

  function automatic logic [31:0] model_out(input int j);
    longint acc = 0;
    longint q;
    logic [31:0] r;
    for (int i = 0; i < NI; i++) acc += longint'(x_mem[i]) * longint'(w_mem[i*NO + j]);
    q = (acc + SC / 2) / SC;
    r = q[31:0] + b_mem[j];
`ifdef DENSE_SEQ_RELU_EN
    if (r[31]) r = 32'd0;
`endif
    return r;
  endfunction

  // Cycle k of the capture is the k-th cycle after the edge that samples start.
  task automatic run_capture(input bit hold, input int ncyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      c_busy[k] = busy; c_done[k] = done; c_we[k] = out_we;
      c_ia[k] = in_addr; c_wa[k] = w_addr; c_ba[k] = b_addr;
      c_oa[k] = out_addr; c_od[k] = out_data;
    end
  endtask

  task automatic set_fill(input int xv, input int wv, input int bv);
    for (int i = 0; i < NI; i++) x_mem[i] = xv;
    for (int i = 0; i < NI*NO; i++) w_mem[i] = wv;
    for (int i = 0; i < NO; i++) b_mem[i] = bv;
  endtask

  task automatic test_reset;
    #12;
    total += 8;
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0)      begin bad++; $display("FAIL reset done: got %b want 0", done); end
    if (out_we !== 1'b0)    begin bad++; $display("FAIL reset out_we: got %b want 0", out_we); end
    if (in_addr !== 16'd0)  begin bad++; $display("FAIL reset in_addr: got %0d want 0", in_addr); end
    if (w_addr !== 16'd0)   begin bad++; $display("FAIL reset w_addr: got %0d want 0", w_addr); end
    if (b_addr !== 16'd0)   begin bad++; $display("FAIL reset b_addr: got %0d want 0", b_addr); end
    if (out_addr !== 16'd0) begin bad++; $display("FAIL reset out_addr: got %0d want 0", out_addr); end
    if (out_data !== 32'd0) begin bad++; $display("FAIL reset out_data: got %0d want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    set_fill(0, 128, 0);
    x_mem[0] = 128; x_mem[1] = 256; x_mem[2] = -128;
    b_mem[0] = 5; b_mem[1] = -10;
    run_capture(1'b0, 13);
    for (int c = 1; c <= 13; c++) begin
      int p = (c - 1) % PER;
      int j = (c - 1) / PER;
      bit in_run = (c <= NO * PER);
      bit e_we = in_run && (p == NI + 1);
      total += 3;
      if (c_busy[c] !== (c <= RUN)) begin bad++; $display("FAIL basic busy c%0d: got %b want %b", c, c_busy[c], c <= RUN); end
      if (c_done[c] !== (c == RUN)) begin bad++; $display("FAIL basic done c%0d: got %b want %b", c, c_done[c], c == RUN); end
      if (c_we[c] !== e_we)         begin bad++; $display("FAIL basic we c%0d: got %b want %b", c, c_we[c], e_we); end
      if (in_run && p < NI) begin
        total += 3;
        if (c_ia[c] !== AW'(p))          begin bad++; $display("FAIL basic in_addr c%0d: got %0d want %0d", c, c_ia[c], p); end
        if (c_wa[c] !== AW'(p * NO + j)) begin bad++; $display("FAIL basic w_addr c%0d: got %0d want %0d", c, c_wa[c], p * NO + j); end
        if (c_ba[c] !== AW'(j))          begin bad++; $display("FAIL basic b_addr c%0d: got %0d want %0d", c, c_ba[c], j); end
      end
      if (e_we) begin
        total += 2;
        if (c_oa[c] !== AW'(j))      begin bad++; $display("FAIL basic out_addr c%0d: got %0d want %0d", c, c_oa[c], j); end
        if (c_od[c] !== model_out(j)) begin bad++; $display("FAIL basic out_data c%0d: got %0d want %0d", c, $signed(c_od[c]), $signed(model_out(j))); end
      end
    end
    total += 2;
    if (c_od[PER] !== 32'd261)     begin bad++; $display("FAIL basic out0: got %0d want 261", $signed(c_od[PER])); end
    if (c_od[2*PER] !== 32'd246)   begin bad++; $display("FAIL basic out1: got %0d want 246", $signed(c_od[2*PER])); end
  endtask

  task automatic test_rounding;
    logic [31:0] e1;
    set_fill(0, 0, 0);
    x_mem[0] = 1; w_mem[0] = -65; w_mem[1] = -192;
`ifdef DENSE_SEQ_RELU_EN
    e1 = 32'd0;
`else
    e1 = 32'hFFFF_FFFF;
`endif
    run_capture(1'b0, 13);
    total += 3;
    if (c_od[PER] !== 32'd0)   begin bad++; $display("FAIL round out0: got %0d want 0", $signed(c_od[PER])); end
    if (c_od[2*PER] !== e1)    begin bad++; $display("FAIL round out1: got %0d want %0d", $signed(c_od[2*PER]), $signed(e1)); end
    if (c_od[2*PER] !== model_out(1)) begin bad++; $display("FAIL round model1: got %0d want %0d", $signed(c_od[2*PER]), $signed(model_out(1))); end
  endtask

  task automatic test_relu;
    logic [31:0] e1;
    set_fill(0, 0, 0);
    x_mem[0] = 1; w_mem[0] = -65; w_mem[1] = -192; b_mem[1] = -3;
`ifdef DENSE_SEQ_RELU_EN
    e1 = 32'd0;
`else
    e1 = 32'hFFFF_FFFC;
`endif
    run_capture(1'b0, 13);
    total += 2;
    if (c_od[PER] !== 32'd0) begin bad++; $display("FAIL relu out0: got %0d want 0", $signed(c_od[PER])); end
    if (c_od[2*PER] !== e1)  begin bad++; $display("FAIL relu out1: got %0d want %0d", $signed(c_od[2*PER]), $signed(e1)); end
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    set_fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    x_mem[2] = 0;
`ifdef DENSE_SEQ_RELU_EN
    e = 32'd0;
`else
    e = 32'hFC00_0000;
`endif
    run_capture(1'b0, 13);
    for (int j = 0; j < NO; j++) begin
      total += 2;
      if (c_od[(j+1)*PER] !== e)            begin bad++; $display("FAIL wrap out%0d: got %h want %h", j, c_od[(j+1)*PER], e); end
      if (c_od[(j+1)*PER] !== model_out(j)) begin bad++; $display("FAIL wrap model%0d: got %h want %h", j, c_od[(j+1)*PER], model_out(j)); end
    end
  endtask

  task automatic test_start_hold;
    int nwe [2];
    set_fill(3, 7, 1);
    run_capture(1'b1, 30);
    start = 1'b0;
    nwe[0] = 0; nwe[1] = 0;
    for (int c = 1; c <= 30; c++) begin
      int cc = (c - 1) % (RUN + 1) + 1;
      int p = (cc - 1) % PER;
      int j = (cc - 1) / PER;
      total += 2;
      if (c_busy[c] !== (cc <= RUN)) begin bad++; $display("FAIL hold busy c%0d: got %b want %b", c, c_busy[c], cc <= RUN); end
      if (c_done[c] !== (cc == RUN)) begin bad++; $display("FAIL hold done c%0d: got %b want %b", c, c_done[c], cc == RUN); end
      if (cc <= NO * PER && p < NI) begin
        total++;
        if (c_wa[c] !== AW'(p * NO + j)) begin bad++; $display("FAIL hold w_addr c%0d: got %0d want %0d", c, c_wa[c], p * NO + j); end
      end
      if (c <= 2 * (RUN + 1) && c_we[c] === 1'b1) nwe[(c - 1) / (RUN + 1)]++;
    end
    for (int r = 0; r < 2; r++) begin
      total++;
      if (nwe[r] !== NO) begin bad++; $display("FAIL hold writes run%0d: got %0d want %0d", r, nwe[r], NO); end
    end
    repeat (16) @(posedge clk);
  endtask

  task automatic test_reset_midrun;
    int seen = 0;
    set_fill(0, 128, 0);
    x_mem[0] = 128; x_mem[1] = 256; x_mem[2] = -128;
    b_mem[0] = 5; b_mem[1] = -10;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total += 2;
    if (busy !== 1'b1)         begin bad++; $display("FAIL midrun busy: got %b want 1", busy); end
    if (out_data !== 32'd261)  begin bad++; $display("FAIL midrun prior: got %0d want 261", $signed(out_data)); end
    #1 rst_n = 1'b0;
    #1;
    total += 5;
    if (busy !== 1'b0)      begin bad++; $display("FAIL abort busy: got %b want 0", busy); end
    if (out_we !== 1'b0)    begin bad++; $display("FAIL abort out_we: got %b want 0", out_we); end
    if (w_addr !== 16'd0)   begin bad++; $display("FAIL abort w_addr: got %0d want 0", w_addr); end
    if (b_addr !== 16'd0)   begin bad++; $display("FAIL abort b_addr: got %0d want 0", b_addr); end
    if (out_data !== 32'd0) begin bad++; $display("FAIL abort out_data: got %0d want 0", out_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_we !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort activity: got %0d cycles want 0", seen); end
    run_capture(1'b0, 13);
    total += 3;
    if (c_od[PER] !== 32'd261)   begin bad++; $display("FAIL rerun out0: got %0d want 261", $signed(c_od[PER])); end
    if (c_od[2*PER] !== 32'd246) begin bad++; $display("FAIL rerun out1: got %0d want 246", $signed(c_od[2*PER])); end
    if (c_done[RUN] !== 1'b1)    begin bad++; $display("FAIL rerun done: got %b want 1", c_done[RUN]); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int nwe = 0;
      for (int i = 0; i < NI; i++)    x_mem[i] = (r % 2 == 0) ? int'($urandom_range(0, 4000)) - 2000 : $urandom;
      for (int i = 0; i < NI*NO; i++) w_mem[i] = (r % 2 == 0) ? int'($urandom_range(0, 4000)) - 2000 : $urandom;
      for (int i = 0; i < NO; i++)    b_mem[i] = (r % 2 == 0) ? int'($urandom_range(0, 400)) - 200 : $urandom;
      run_capture(1'b0, 13);
      for (int c = 1; c <= 13; c++) if (c_we[c] === 1'b1) nwe++;
      total += 2;
      if (nwe != NO)            begin bad++; $display("FAIL rand%0d writes: got %0d want %0d", r, nwe, NO); end
      if (c_done[RUN] !== 1'b1) begin bad++; $display("FAIL rand%0d done: got %b want 1", r, c_done[RUN]); end
      for (int j = 0; j < NO; j++) begin
        total += 2;
        if (c_oa[(j+1)*PER] !== AW'(j))      begin bad++; $display("FAIL rand%0d addr%0d: got %0d want %0d", r, j, c_oa[(j+1)*PER], j); end
        if (c_od[(j+1)*PER] !== model_out(j)) begin bad++; $display("FAIL rand%0d out%0d: got %h want %h", r, j, c_od[(j+1)*PER], model_out(j)); end
      end
    end
  endtask

  initial begin
    set_fill(0, 0, 0);
    test_reset;
    test_basic;
    test_rounding;
    test_relu;
    test_wrap;
    test_start_hold;
    test_reset_midrun;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
